// File: rtl/multi_timer.sv
// Multi-channel programmable timer: a shared prescaler tick drives per-channel
// free-run, periodic-reload and one-shot counters with sticky expiry flags and irq.
module multi_timer #(
    parameter int unsigned CHANNELS          = 4,
    parameter int unsigned COUNTER_WIDTH     = 16,
    parameter int unsigned PRESCALE_WIDTH    = 15,
    parameter int unsigned PRESCALE_INTERVAL = 24000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cs,
    input  logic                            wr,
    input  logic                            rd,
    input  logic [$clog2(CHANNELS)+2-1:0]   addr,
    input  logic [COUNTER_WIDTH-1:0]        din,
    output logic [COUNTER_WIDTH-1:0]        dout,
    output logic                            tick,
    output logic                            irq
);

    localparam int unsigned ADDR_W = $clog2(CHANNELS) + 2;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_e;

    logic [PRESCALE_WIDTH-1:0] divider;

    logic [CHANNELS-1:0]                    en_q, en_d;
    logic [CHANNELS-1:0]                    irq_en_q, irq_en_d;
    logic [CHANNELS-1:0]                    expired_q, expired_d;
    logic [CHANNELS-1:0]                    expire_set, expire_clr;
    mode_e                                  mode_q [CHANNELS];
    mode_e                                  mode_d [CHANNELS];
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] reload_q, reload_d;

    logic [ADDR_W-1:0]        ch_sel;
    reg_e                     reg_sel;
    logic                     wr_en;
    logic                     rd_en;
    logic [COUNTER_WIDTH-1:0] rdata;

    assign ch_sel  = addr >> 2;
    assign reg_sel = reg_e'(addr[1:0]);
    assign wr_en   = cs && wr;
    assign rd_en   = cs && rd;

    // Free-running prescaler; tick is the terminal-count cycle.
    assign tick = reset_n && (divider == PRESCALE_WIDTH'(PRESCALE_INTERVAL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
        end else if (tick) begin
            divider <= '0;
        end else begin
            divider <= divider + PRESCALE_WIDTH'(1);
        end
    end

    // Channel next state: tick action on old CTRL first, bus writes then override.
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        mode_d     = mode_q;
        count_d    = count_q;
        reload_d   = reload_q;
        expire_set = '0;
        expire_clr = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            if (tick && en_q[i]) begin
                unique case (mode_q[i])
                    MODE_FREE: begin
                        count_d[i] = count_q[i] + COUNTER_WIDTH'(1);
                        if (count_q[i] == '1) begin
                            expire_set[i] = 1'b1;
                        end
                    end
                    MODE_PERIODIC: begin
                        if (count_q[i] == '0) begin
                            count_d[i]    = reload_q[i];
                            expire_set[i] = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] - COUNTER_WIDTH'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (count_q[i] == '0) begin
                            expire_set[i] = 1'b1;
                            en_d[i]       = 1'b0;
                        end else begin
                            count_d[i] = count_q[i] - COUNTER_WIDTH'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (wr_en && (ch_sel == ADDR_W'(i))) begin
                unique case (reg_sel)
                    REG_CTRL: begin
                        en_d[i]     = din[0];
                        mode_d[i]   = mode_e'(din[2:1]);
                        irq_en_d[i] = din[3];
                    end
                    REG_RELOAD: begin
                        reload_d[i] = din;
                    end
                    REG_COUNT: begin
                        count_d[i]    = din;
                        expire_set[i] = 1'b0;
                    end
                    REG_STATUS: begin
                        expire_clr[i] = din[0];
                    end
                    default: begin
                    end
                endcase
            end
        end

        // A coincident expiry beats a clear.
        expired_d = expire_set | (expired_q & ~expire_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= '0;
            irq_en_q  <= '0;
            expired_q <= '0;
            count_q   <= '0;
            reload_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= MODE_FREE;
            end
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            expired_q <= expired_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= mode_d[i];
            end
        end
    end

    // Read mux over the pre-write register values; unmatched channels read 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                unique case (reg_sel)
                    REG_CTRL:   rdata = COUNTER_WIDTH'({irq_en_q[i], mode_q[i], en_q[i]});
                    REG_RELOAD: rdata = reload_q[i];
                    REG_COUNT:  rdata = count_q[i];
                    REG_STATUS: rdata = COUNTER_WIDTH'(expired_q[i]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= rdata;
        end
    end

    assign irq = |(expired_q & irq_en_q);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: prescaler cadence, the three counting modes,
// bus corner cases and asynchronous reset, with hand-computed expectations.
module tb_multi_timer;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 15;
    localparam int unsigned PI = 3;
    localparam int unsigned AW = $clog2(CH) + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [CW-1:0] din;
    logic [CW-1:0] dout;
    logic          tick;
    logic          irq;

    int tests_run  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    multi_timer #(
        .CHANNELS         (CH),
        .COUNTER_WIDTH    (CW),
        .PRESCALE_WIDTH   (PW),
        .PRESCALE_INTERVAL(PI)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cs     (cs),
        .wr     (wr),
        .rd     (rd),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .tick   (tick),
        .irq    (irq)
    );

    // All bus ops start at a negedge and end at the following negedge.
    task automatic bus_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [CW-1:0] d);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = dout;
    endtask

    // Returns at a negedge where tick is high, so the next posedge is a tick edge.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            tests_run++;
            fail_count++;
            $display("FAIL wait_tick: tick=%b after 8 clk, required 1", tick);
        end
    endtask

    task automatic test_reset();
        logic exp_tick;
        reset_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (dout !== 16'h0 || tick !== 1'b0 || irq !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_outputs: dout=%h tick=%b irq=%b, required 0/0/0", dout, tick, irq);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_tick = ((k % 4) == 3);
            tests_run++;
            if (tick !== exp_tick) begin
                fail_count++;
                $display("FAIL tick_cadence clk %0d: got %b required %b", k, tick, exp_tick);
            end
        end
        tests_run++;
        if (dout !== 16'h0 || irq !== 1'b0) begin
            fail_count++;
            $display("FAIL idle_outputs: dout=%h irq=%b, required 0/0", dout, irq);
        end
    endtask

    task automatic test_periodic();
        logic [CW-1:0] exp_cnt [6] = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};
        logic          exp_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [CW-1:0] d;
        wait_tick();
        @(negedge clk);
        bus_write(4'd1, 16'd2);
        bus_write(4'd2, 16'd2);
        bus_write(4'd0, 16'h000B);
        for (int t = 0; t < 6; t++) begin
            wait_tick();
            @(negedge clk);
            tests_run++;
            if (irq !== exp_exp[t]) begin
                fail_count++;
                $display("FAIL periodic_irq tick %0d: got %b required %b", t + 1, irq, exp_exp[t]);
            end
            bus_read(4'd2, d);
            tests_run++;
            if (d !== exp_cnt[t]) begin
                fail_count++;
                $display("FAIL periodic_count tick %0d: got %h required %h", t + 1, d, exp_cnt[t]);
            end
            bus_read(4'd3, d);
            tests_run++;
            if (d !== CW'(exp_exp[t])) begin
                fail_count++;
                $display("FAIL periodic_status tick %0d: got %h required %h", t + 1, d, CW'(exp_exp[t]));
            end
        end
        bus_write(4'd0, 16'h0000);
        bus_write(4'd3, 16'h0001);
        tests_run++;
        if (irq !== 1'b0) begin
            fail_count++;
            $display("FAIL periodic_clear_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_oneshot();
        logic [CW-1:0] exp_st   [3] = '{16'd0, 16'd1, 16'd1};
        logic [CW-1:0] exp_ctrl [3] = '{16'h5, 16'h4, 16'h4};
        logic [CW-1:0] d;
        wait_tick();
        @(negedge clk);
        bus_write(4'd6, 16'd1);
        bus_write(4'd4, 16'h0005);
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            @(negedge clk);
            bus_read(4'd6, d);
            tests_run++;
            if (d !== 16'd0) begin
                fail_count++;
                $display("FAIL oneshot_count tick %0d: got %h required 0000", t + 1, d);
            end
            bus_read(4'd7, d);
            tests_run++;
            if (d !== exp_st[t]) begin
                fail_count++;
                $display("FAIL oneshot_status tick %0d: got %h required %h", t + 1, d, exp_st[t]);
            end
            bus_read(4'd4, d);
            tests_run++;
            if (d !== exp_ctrl[t] || irq !== 1'b0) begin
                fail_count++;
                $display("FAIL oneshot_ctrl tick %0d: ctrl=%h irq=%b required %h/0", t + 1, d, irq, exp_ctrl[t]);
            end
        end
    endtask

    task automatic test_freerun();
        logic [CW-1:0] exp_cnt [2] = '{16'hFFFF, 16'h0000};
        logic [CW-1:0] exp_st  [2] = '{16'd0, 16'd1};
        logic [CW-1:0] d;
        wait_tick();
        @(negedge clk);
        bus_write(4'd10, 16'hFFFE);
        bus_write(4'd8, 16'h0001);
        for (int t = 0; t < 2; t++) begin
            wait_tick();
            @(negedge clk);
            bus_read(4'd10, d);
            tests_run++;
            if (d !== exp_cnt[t]) begin
                fail_count++;
                $display("FAIL freerun_count tick %0d: got %h required %h", t + 1, d, exp_cnt[t]);
            end
            bus_read(4'd11, d);
            tests_run++;
            if (d !== exp_st[t] || irq !== 1'b0) begin
                fail_count++;
                $display("FAIL freerun_status tick %0d: status=%h irq=%b required %h/0", t + 1, d, irq, exp_st[t]);
            end
        end
        bus_write(4'd8, 16'h0000);
    endtask

    task automatic test_clear_vs_expiry();
        logic [CW-1:0] d;
        wait_tick();
        @(negedge clk);
        bus_write(4'd2, 16'd0);
        bus_write(4'd0, 16'h000B);
        wait_tick();
        tests_run++;
        if (irq !== 1'b0) begin
            fail_count++;
            $display("FAIL clear_pre_irq: got %b required 0", irq);
        end
        bus_write(4'd3, 16'h0001);
        tests_run++;
        if (irq !== 1'b1) begin
            fail_count++;
            $display("FAIL clear_vs_set_irq: got %b required 1", irq);
        end
        bus_write(4'd3, 16'h0001);
        tests_run++;
        if (irq !== 1'b0) begin
            fail_count++;
            $display("FAIL clear_irq_drop: got %b required 0", irq);
        end
        bus_read(4'd3, d);
        tests_run++;
        if (d !== 16'd0) begin
            fail_count++;
            $display("FAIL clear_status: got %h required 0000", d);
        end
        bus_read(4'd2, d);
        tests_run++;
        if (d !== 16'd2) begin
            fail_count++;
            $display("FAIL clear_reloaded_count: got %h required 0002", d);
        end
        bus_write(4'd0, 16'h0000);
    endtask

    task automatic test_async_reset();
        logic [CW-1:0] d;
        bus_write(4'd2, 16'd0);
        bus_write(4'd0, 16'h000B);
        wait_tick();
        @(negedge clk);
        bus_read(4'd1, d);
        tests_run++;
        if (d !== 16'd2 || irq !== 1'b1) begin
            fail_count++;
            $display("FAIL prereset_state: reload=%h irq=%b required 0002/1", d, irq);
        end
        wait_tick();
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (dout !== 16'h0 || tick !== 1'b0 || irq !== 1'b0) begin
            fail_count++;
            $display("FAIL async_reset: dout=%h tick=%b irq=%b required 0/0/0", dout, tick, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(4'd1, d);
        tests_run++;
        if (d !== 16'h0) begin
            fail_count++;
            $display("FAIL reset_reload: got %h required 0000", d);
        end
        bus_read(4'd0, d);
        tests_run++;
        if (d !== 16'h0) begin
            fail_count++;
            $display("FAIL reset_ctrl: got %h required 0000", d);
        end
    endtask

    task automatic test_count_write_vs_tick();
        logic [CW-1:0] d;
        bus_write(4'd1, 16'd9);
        bus_write(4'd2, 16'd0);
        bus_write(4'd0, 16'h0003);
        wait_tick();
        bus_write(4'd2, 16'd5);
        bus_read(4'd2, d);
        tests_run++;
        if (d !== 16'd5) begin
            fail_count++;
            $display("FAIL count_write_wins: got %h required 0005", d);
        end
        bus_read(4'd3, d);
        tests_run++;
        if (d !== 16'd0) begin
            fail_count++;
            $display("FAIL count_write_no_expiry: got %h required 0000", d);
        end
        wait_tick();
        @(negedge clk);
        bus_read(4'd2, d);
        tests_run++;
        if (d !== 16'd4) begin
            fail_count++;
            $display("FAIL count_after_write: got %h required 0004", d);
        end
        bus_write(4'd0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] d;
        bus_write(4'd13, 16'h1234);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'd13; din = 16'hABCD;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        tests_run++;
        if (dout !== 16'h1234) begin
            fail_count++;
            $display("FAIL rw_prewrite: got %h required 1234", dout);
        end
        bus_read(4'd13, d);
        tests_run++;
        if (d !== 16'hABCD) begin
            fail_count++;
            $display("FAIL rw_written: got %h required abcd", d);
        end
        bus_write(4'd12, 16'hFFF8);
        bus_read(4'd12, d);
        tests_run++;
        if (d !== 16'h0008) begin
            fail_count++;
            $display("FAIL ctrl_masking: got %h required 0008", d);
        end
        wait_tick();
        @(negedge clk);
        bus_write(4'd14, 16'd5);
        bus_write(4'd12, 16'h0003);
        wait_tick();
        bus_write(4'd12, 16'h0000);
        bus_read(4'd14, d);
        tests_run++;
        if (d !== 16'd4) begin
            fail_count++;
            $display("FAIL ctrl_vs_tick_old: got %h required 0004", d);
        end
        wait_tick();
        @(negedge clk);
        bus_read(4'd14, d);
        tests_run++;
        if (d !== 16'd4) begin
            fail_count++;
            $display("FAIL ctrl_vs_tick_hold: got %h required 0004", d);
        end
        bus_write(4'd14, 16'd0);
        bus_write(4'd12, 16'h0005);
        wait_tick();
        bus_write(4'd12, 16'h0005);
        bus_read(4'd12, d);
        tests_run++;
        if (d !== 16'h0005) begin
            fail_count++;
            $display("FAIL oneshot_vs_ctrl_enable: got %h required 0005", d);
        end
        bus_read(4'd15, d);
        tests_run++;
        if (d !== 16'd1) begin
            fail_count++;
            $display("FAIL oneshot_vs_ctrl_status: got %h required 0001", d);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_freerun();
        test_clear_vs_expiry();
        test_async_reset();
        test_count_write_vs_tick();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
